// File: rtl/done_launcher_pkg.sv
// Shared definitions for the ld/done handshake blocks: state encodings,
// fault codes and the cnt width helper.
package done_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RESP  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_EARLY    = 3'd1;
    localparam logic [2:0] FC_TIMEOUT  = 3'd2;
    localparam logic [2:0] FC_SPURIOUS = 3'd3;
    localparam logic [2:0] FC_STATE    = 3'd4;

    // Wide enough to hold LATENCY+TMO_SLACK+1 without wrapping.
    function automatic int unsigned cnt_width(input int unsigned latency,
                                              input int unsigned slack);
        return $clog2(latency + slack + 2);
    endfunction

endpackage

// File: rtl/done_window_chk.sv
// Classifies a done strobe against the expected latency window.
// Purely combinational; shared with the receiver-side checker.
module done_window_chk #(
    parameter int unsigned LATENCY   = 11,
    parameter int unsigned TMO_SLACK = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             done,
    output logic             early,
    output logic             ok,
    output logic             late,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] HI_C  = CNT_W'(LATENCY + TMO_SLACK);

    always_comb begin
        early   = done && (cnt < LAT_C);
        ok      = done && (cnt >= LAT_C) && (cnt <= HI_C);
        late    = done && (cnt > LAT_C) && (cnt <= HI_C);
        timeout = (cnt > HI_C);
    end

endmodule

// File: rtl/done_launcher.sv
// Initiator side of the ld/done handshake with done-timing fault detection.
// Optional macro DONE_LAUNCHER_DUP_STATE_EN adds an inverted shadow of state/cnt.
module done_launcher
    import done_pkg::*;
#(
    parameter int unsigned LATENCY   = 11,
    parameter int unsigned TMO_SLACK = 2,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    output logic             ld,
    input  logic             done,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_late,
    output logic             fault,
    output logic [2:0]       fault_code,
    input  logic             clear_fault
);

    localparam int unsigned CNT_W = cnt_width(LATENCY, TMO_SLACK);

    logic [2:0]       state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [2:0]       code_nxt;
    logic             w_early, w_ok, w_late, w_tmo;
    logic             st_err;

    done_window_chk #(
        .LATENCY  (LATENCY),
        .TMO_SLACK(TMO_SLACK),
        .CNT_W    (CNT_W)
    ) u_win (
        .cnt    (cnt),
        .done   (done),
        .early  (w_early),
        .ok     (w_ok),
        .late   (w_late),
        .timeout(w_tmo)
    );

    assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

`ifdef DONE_LAUNCHER_DUP_STATE_EN
    logic [2:0]       state_n;
    logic [CNT_W-1:0] cnt_n;

    assign st_err = (state != ~state_n) || (cnt != ~cnt_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_n <= ~S_IDLE;
            cnt_n   <= '1;
        end else begin
            state_n <= ~nxt;
            cnt_n   <= ~cnt_nxt;
        end
    end
`else
    assign st_err = 1'b0;
`endif

    always_comb begin
        nxt      = state;
        cnt_nxt  = cnt;
        code_nxt = fault_code;
        case (state)
            S_IDLE: begin
                if (done) begin
                    nxt      = S_FAULT;
                    code_nxt = FC_SPURIOUS;
                end else if (req_valid) begin
                    nxt     = S_LOAD;
                    cnt_nxt = '0;
                end
            end
            S_LOAD: begin
                if (done) begin
                    nxt      = S_FAULT;
                    code_nxt = FC_SPURIOUS;
                end else begin
                    nxt     = S_WAIT;
                    cnt_nxt = cnt_inc;
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt_inc;
                // A done inside the window beats the timeout boundary.
                if (w_early) begin
                    nxt      = S_FAULT;
                    code_nxt = FC_EARLY;
                end else if (w_ok) begin
                    nxt = S_RESP;
                end else if (w_tmo) begin
                    nxt      = S_FAULT;
                    code_nxt = FC_TIMEOUT;
                end
            end
            S_RESP: begin
                if (done) begin
                    nxt      = S_FAULT;
                    code_nxt = FC_SPURIOUS;
                end else if (resp_ready) begin
                    nxt = S_IDLE;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    nxt      = S_IDLE;
                    code_nxt = FC_NONE;
                end
            end
            default: nxt = S_IDLE;
        endcase
        // Shadow mismatch overrides everything except a clear, which resyncs both copies.
        if (st_err && !(state == S_FAULT && clear_fault)) begin
            nxt = S_FAULT;
            if (fault_code == FC_NONE) code_nxt = FC_STATE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            fault_code <= FC_NONE;
            ld         <= 1'b0;
            resp_tag   <= '0;
            resp_late  <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= cnt_nxt;
            fault_code <= code_nxt;
            ld         <= (nxt == S_LOAD);
            if (state == S_IDLE && nxt == S_LOAD) resp_tag <= req_tag;
            if (state == S_WAIT && nxt == S_RESP) resp_late <= w_late;
        end
    end

    assign req_ready  = (state == S_IDLE) && !rst;
    assign resp_valid = (state == S_RESP);
    assign fault      = (state == S_FAULT);

endmodule

// File: doc/done_launcher.md
Name: done_launcher

Overview:
- Initiator side of the ld/done handshake used by the round-counter blocks.
- Accepts jobs on a valid/ready interface, issues a one-cycle ld pulse to the fixed-latency core and waits for the core's done.
- Returns a tagged response on a valid/ready interface.
- Checks done timing against the expected latency window and raises sticky fault flags (early, timeout, spurious) for the fault-injection assessment flow.

Parameters:
- LATENCY, 11, cycles from the ld cycle to the expected done cycle; minimum 2.
- TMO_SLACK, 2, extra cycles after LATENCY during which a late done is still accepted.
- TAG_W, 4, width of the job tag carried from request to response.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  job request.
- req_ready  output  1  high only in IDLE with no fault pending.
- req_tag  input  TAG_W  tag captured on a req handshake.
- ld  output  1  registered load pulse to the core.
- done  input  1  completion strobe from the core.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts the response.
- resp_tag  output  TAG_W  tag of the completed job.
- resp_late  output  1  done arrived after LATENCY but within the slack window.
- fault  output  1  sticky fault flag.
- fault_code  output  3  0 none, 1 EARLY, 2 TIMEOUT, 3 SPURIOUS, 4 STATE.
- clear_fault  input  1  synchronous clear of fault; honoured only in the FAULT state.

Behaviour:
Reset values:
- All outputs 0; state IDLE; cnt 0.
- A reset mid-job drops ld immediately and abandons the job; no response is produced.

State machine (IDLE, LOAD, WAIT, RESP, FAULT):
- IDLE: req_ready=1. When req_valid is seen: capture req_tag, go to LOAD.
- LOAD: exactly one cycle, ld=1, cnt set to 0, then go to WAIT. There is no back-to-back ld.
- WAIT: cnt increments each cycle, so cnt=k in the k-th cycle after the ld cycle.
  - done with cnt<LATENCY: fault, code EARLY.
  - done with LATENCY<=cnt<=LATENCY+TMO_SLACK: go to RESP. Set resp_late=1 if cnt>LATENCY.
  - cnt reaching LATENCY+TMO_SLACK+1 without done: fault, code TIMEOUT.
- RESP: resp_valid=1, and resp_tag/resp_late stay stable until resp_ready. On the handshake, go to IDLE with resp_valid=0 the next cycle.
- done seen in IDLE, LOAD or RESP: fault, code SPURIOUS.

Fault handling:
- Entering FAULT: fault=1, fault_code latched, resp_valid forced 0, req_ready=0.
- The first fault wins; later events do not overwrite fault_code.
- clear_fault in FAULT: fault and fault_code return to 0, state returns to IDLE next cycle. clear_fault is ignored in every other state.
- Simultaneous done and the timeout boundary: done takes priority, since it falls within the window by definition.

Arithmetic:
- cnt width is $clog2(LATENCY+TMO_SLACK+2).
- cnt saturates and never wraps.

Latency:
- req handshake to ld = 1 cycle.
- done to resp_valid = 1 cycle.

Optional Feature:
- Macro: DONE_LAUNCHER_DUP_STATE_EN.
- With the macro defined:
  - The state register and cnt are duplicated, the copy stored bit-inverted.
  - Both copies are compared every cycle.
  - A mismatch forces FAULT with code STATE, taking precedence over any same-cycle event.
  - clear_fault also resynchronises the copy.
- Without the macro: a single state register, and code 4 is never produced.

Decomposition:
- Shared package done_pkg holds:
  - the state enum (IDLE, LOAD, WAIT, RESP, FAULT);
  - the fault_code localparams (FC_NONE, FC_EARLY, FC_TIMEOUT, FC_SPURIOUS, FC_STATE);
  - a function computing the cnt width.
- One natural sub-module, done_window_chk: takes cnt and done, returns early/ok/late/timeout as purely combinational outputs. It is reused by the receiver-side checker.

Test Plan:
1. Nominal job, LATENCY=11: req_valid with tag 0x5; ld pulses one cycle later; done at cnt=11 -> resp_valid next cycle, resp_tag=0x5, resp_late=0, fault=0.
2. Late within slack: done at cnt=13 -> response with resp_late=1. Then done at cnt=14 on a second job -> fault=1, code 2; req_ready stays 0 until clear_fault.
3. Early done at cnt=4 -> fault, code 1. Check clear_fault is ignored outside FAULT, then clear_fault returns the block to IDLE with fault_code=0.
4. Spurious done in IDLE, and again while resp_valid is held with resp_ready=0 -> code 3. Check resp_valid drops to 0 in the same cycle fault rises.
5. Backpressure then reset: hold resp_ready=0 for 5 cycles (tag and resp_late stable); then assert rst mid-WAIT of the next job -> ld=0 and all outputs 0 asynchronously; the next job completes normally.
6. With DONE_LAUNCHER_DUP_STATE_EN defined: force-flip one state copy bit during WAIT -> fault, code 4, on the next edge, even if done arrives in the same cycle.
